// File: rtl/clk_div_pkg.sv
// Shared definitions for the multi-channel clock divider.
//   DIV_MIN      smallest usable divisor (clk_in/2 is the fastest output)
//   chan_state_e per-channel run state
//   clamp_div    raise a requested divisor to at least DIV_MIN
package clk_div_pkg;

  localparam int unsigned DIV_MIN = 2;

  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } chan_state_e;

  // Operates on a 64-bit container so one function serves any DIV_W <= 64.
  function automatic logic [63:0] clamp_div(input logic [63:0] div);
    return (div < 64'(DIV_MIN)) ? 64'(DIV_MIN) : div;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: generates a registered divided clock and a one-cycle
// tick strobe that is high in the cycle the divided clock rises.
// Ports:
//   clk_in   board clock, all logic on posedge
//   rst_n    asynchronous active-low reset
//   en       run enable (level); low truncates the current period immediately
//   sync     one-cycle pulse restarting the period if running
//   div_in   requested divisor, sampled only at period start
//   clk_out  divided clock, high for floor(d/2) cycles of each d-cycle period
//   tick     strobe coincident with the rising edge of clk_out
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV_W = 32
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync,
  input  logic [DIV_W-1:0] div_in,
  output logic             clk_out,
  output logic             tick
);

  chan_state_e      state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_act_q, div_act_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;

  logic [DIV_W-1:0] div_eff;
  logic [DIV_W-1:0] cnt_inc;

  assign div_eff = DIV_W'(clamp_div(64'(div_in)));
  // cnt never exceeds div_act-1, so the increment cannot wrap.
  assign cnt_inc = cnt_q + DIV_W'(1);

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CH_IDLE;
      cnt_q     <= '0;
      div_act_q <= DIV_W'(DIV_MIN);
      clk_q     <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_act_q <= div_act_d;
      clk_q     <= clk_d;
      tick_q    <= tick_d;
    end
  end

  // The divisor is latched only when a new period begins, so a change on
  // div_in never shortens the period in progress.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_act_d = div_act_q;
    clk_d     = clk_q;
    tick_d    = 1'b0;
    if (!en) begin
      state_d = CH_IDLE;
      cnt_d   = '0;
      clk_d   = 1'b0;
    end else if (state_q == CH_IDLE || sync) begin
      state_d   = CH_RUN;
      cnt_d     = '0;
      div_act_d = div_eff;
      clk_d     = 1'b1;
      tick_d    = 1'b1;
    end else if (cnt_q == div_act_q - DIV_W'(1)) begin
      cnt_d     = '0;
      div_act_d = div_eff;
      clk_d     = 1'b1;
      tick_d    = 1'b1;
    end else begin
      cnt_d = cnt_inc;
      clk_d = (cnt_inc < (div_act_q >> 1));
    end
  end

  assign clk_out = clk_q;
  assign tick    = tick_q;

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel clock divider / clock-enable generator.
// Each channel runs independently from its own divisor and enable; the only
// shared control is sync, which restarts every running channel in phase.
// Prefer tick[] as a clock enable; clk_out[] is meant for pins or a clock buffer.
// Ports:
//   clk_in   board clock
//   rst_n    asynchronous active-low reset
//   en       per-channel run enable
//   sync     one-cycle pulse, phase-align all running channels
//   div_in   divisors, channel i at [i*DIV_W +: DIV_W]
//   clk_out  per-channel divided clock
//   tick     per-channel strobe, high in the cycle clk_out rises
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned DIV_W    = 32
) (
  input  logic                      clk_in,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       en,
  input  logic                      sync,
  input  logic [CHANNELS*DIV_W-1:0] div_in,
  output logic [CHANNELS-1:0]       clk_out,
  output logic [CHANNELS-1:0]       tick
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    clk_div_chan #(
      .DIV_W (DIV_W)
    ) u_chan (
      .clk_in  (clk_in),
      .rst_n   (rst_n),
      .en      (en[i]),
      .sync    (sync),
      .div_in  (div_in[i*DIV_W +: DIV_W]),
      .clk_out (clk_out[i]),
      .tick    (tick[i])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
module tb_clk_div_multi;

  localparam int unsigned CH = 4;
  localparam int unsigned DW = 32;

  logic             clk_in;
  logic             rst_n;
  logic [CH-1:0]    en;
  logic             sync;
  logic [CH*DW-1:0] div_in;
  logic [CH-1:0]    clk_out;
  logic [CH-1:0]    tick;

  int unsigned n_checks;
  int unsigned n_fail;

  typedef struct {
    logic [31:0] div;
    int unsigned hi;
    int unsigned lo;
    int unsigned periods;
  } ratio_vec_t;

  ratio_vec_t vecs[8];

  clk_div_multi #(
    .CHANNELS (CH),
    .DIV_W    (DW)
  ) dut (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .en      (en),
    .sync    (sync),
    .div_in  (div_in),
    .clk_out (clk_out),
    .tick    (tick)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_div(input int unsigned ch, input logic [31:0] val);
    div_in[ch*DW +: DW] = val;
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%b required=%b at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    int unsigned chi[4];
    int unsigned cper[4];
    logic [3:0]  ec, et;
    n_checks = 0;
    n_fail   = 0;
    chi  = '{1, 1, 2, 2};
    cper = '{2, 3, 4, 5};

    vecs[0] = '{div: 32'd2, hi: 1, lo: 1, periods: 100};
    vecs[1] = '{div: 32'd3, hi: 1, lo: 2, periods: 100};
    vecs[2] = '{div: 32'd4, hi: 2, lo: 2, periods: 100};
    vecs[3] = '{div: 32'd5, hi: 2, lo: 3, periods: 100};
    vecs[4] = '{div: 32'd0, hi: 1, lo: 1, periods: 10};
    vecs[5] = '{div: 32'd1, hi: 1, lo: 1, periods: 10};
    vecs[6] = '{div: 32'd7, hi: 3, lo: 4, periods: 10};
    vecs[7] = '{div: 32'd8, hi: 4, lo: 4, periods: 10};

    // Reset hold and first tick after release
    rst_n  = 1'b0;
    en     = '1;
    sync   = 1'b0;
    div_in = '0;
    for (int unsigned c = 0; c < CH; c++) set_div(c, 32'd4);
    repeat (3) step();
    check("rst_hold_clk", clk_out, 4'h0);
    check("rst_hold_tick", tick, 4'h0);
    rst_n = 1'b1;
    step();
    check("rst_first_tick", tick, 4'hF);
    check("rst_first_clk", clk_out, 4'hF);
    step();
    check("rst_k1_clk", clk_out, 4'hF);
    check("rst_k1_tick", tick, 4'h0);
    step();
    check("rst_k2_clk", clk_out, 4'h0);
    step();
    check("rst_k3_clk", clk_out, 4'h0);
    step();
    check("rst_k4_tick", tick, 4'hF);

    // Ratio and clamp table, same divisor on every channel
    for (int unsigned v = 0; v < 8; v++) begin
      int unsigned per;
      string nm;
      per = vecs[v].hi + vecs[v].lo;
      nm  = $sformatf("ratio_div%0d", vecs[v].div);
      en  = '0;
      step();
      for (int unsigned c = 0; c < CH; c++) set_div(c, vecs[v].div);
      en = '1;
      for (int unsigned k = 0; k < per * vecs[v].periods; k++) begin
        step();
        check({nm, "_clk"}, clk_out, ((k % per) < vecs[v].hi) ? 4'hF : 4'h0);
        check({nm, "_tick"}, tick, ((k % per) == 0) ? 4'hF : 4'h0);
      end
    end

    // Four channels concurrently at 2,3,4,5
    en = '0;
    step();
    for (int unsigned c = 0; c < CH; c++) set_div(c, cper[c]);
    en = '1;
    for (int unsigned k = 0; k < 60; k++) begin
      step();
      for (int unsigned c = 0; c < CH; c++) begin
        ec[c] = (k % cper[c]) < chi[c];
        et[c] = (k % cper[c]) == 0;
      end
      check("multi_clk", clk_out, ec);
      check("multi_tick", tick, et);
    end

    // Divisor change 8 -> 3 at cnt=2
    en = '0;
    step();
    set_div(0, 32'd8);
    en = 4'b0001;
    step();
    check("chg_k0_tick", tick, 4'b0001);
    step();
    step();
    set_div(0, 32'd3);
    for (int unsigned k = 3; k < 15; k++) begin
      step();
      if (k < 8) begin
        ec[0] = (k < 4);
        et[0] = 1'b0;
      end else begin
        ec[0] = ((k - 8) % 3) == 0;
        et[0] = ((k - 8) % 3) == 0;
      end
      check("chg_clk", {3'b000, clk_out[0]}, {3'b000, ec[0]});
      check("chg_tick", {3'b000, tick[0]}, {3'b000, et[0]});
    end

    // Sync: ch0 d=6 at cnt=4, ch1 d=10 at cnt=7, ch2/ch3 disabled
    en = '0;
    step();
    set_div(0, 32'd6);
    set_div(1, 32'd10);
    en = 4'b0010;
    step();
    check("sync_ch1_start", tick, 4'b0010);
    step();
    step();
    en = 4'b0011;
    step();
    check("sync_ch0_start_tick", tick, 4'b0001);
    check("sync_ch0_start_clk", clk_out, 4'b0011);
    repeat (4) step();
    check("sync_pre_clk", clk_out, 4'b0000);
    check("sync_pre_tick", tick, 4'b0000);
    sync = 1'b1;
    step();
    sync = 1'b0;
    check("sync_edge_tick", tick, 4'b0011);
    check("sync_edge_clk", clk_out, 4'b0011);
    for (int unsigned s = 1; s < 30; s++) begin
      step();
      ec = {2'b00, (s % 10) < 5, (s % 6) < 3};
      et = {2'b00, (s % 10) == 0, (s % 6) == 0};
      check("sync_run_clk", clk_out, ec);
      check("sync_run_tick", tick, et);
    end
    en   = '0;
    sync = 1'b1;
    step();
    sync = 1'b0;
    check("sync_disabled_clk", clk_out, 4'h0);
    check("sync_disabled_tick", tick, 4'h0);

    // Enable drop mid-high-phase and restart
    step();
    set_div(0, 32'd6);
    en = 4'b0001;
    step();
    check("en_start_tick", tick, 4'b0001);
    step();
    check("en_high_clk", clk_out, 4'b0001);
    en = '0;
    step();
    check("en_drop_clk", clk_out, 4'b0000);
    check("en_drop_tick", tick, 4'b0000);
    step();
    check("en_idle_clk", clk_out, 4'b0000);
    en = 4'b0001;
    step();
    check("en_restart_tick", tick, 4'b0001);
    check("en_restart_clk", clk_out, 4'b0001);
    for (int unsigned k = 1; k < 12; k++) begin
      step();
      check("en_period_clk", {3'b000, clk_out[0]}, {3'b000, (k % 6) < 3});
      check("en_period_tick", {3'b000, tick[0]}, {3'b000, (k % 6) == 0});
    end

    // Asynchronous reset mid-operation
    en = '0;
    step();
    for (int unsigned c = 0; c < CH; c++) set_div(c, 32'd3);
    en = '1;
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    check("arst_clk", clk_out, 4'h0);
    check("arst_tick", tick, 4'h0);
    step();
    check("arst_hold_clk", clk_out, 4'h0);
    rst_n = 1'b1;
    step();
    check("arst_rel_tick", tick, 4'hF);
    check("arst_rel_clk", clk_out, 4'hF);
    step();
    check("arst_k1_clk", clk_out, 4'h0);
    check("arst_k1_tick", tick, 4'h0);

    // All-ones divisor: very long high phase
    en = '0;
    step();
    set_div(0, 32'hFFFF_FFFF);
    en = 4'b0001;
    step();
    check("max_start_tick", tick, 4'b0001);
    for (int unsigned k = 1; k <= 20; k++) begin
      step();
      check("max_clk", clk_out, 4'b0001);
      check("max_tick", tick, 4'b0000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
